// File: rtl/synth_pkg.sv
// Shared constants, register map and envelope types for the two-voice synthesizer.
package synth_pkg;

    localparam int VOICES      = 2;
    localparam int PHASE_SHIFT = 16;
    localparam int ENV_SHIFT   = 14;
    localparam int PHASE_W     = 24;
    localparam int ENV_W       = 24;
    localparam int SAMPLE_W    = 24;
    localparam int LFSR_W      = 23;

    localparam logic [3:0] OFF_GATE    = 4'h0;
    localparam logic [3:0] OFF_INCR    = 4'h1;
    localparam logic [3:0] OFF_SHAPE   = 4'h2;
    localparam logic [3:0] OFF_PW      = 4'h3;
    localparam logic [3:0] OFF_ATTACK  = 4'h4;
    localparam logic [3:0] OFF_DECAY   = 4'h5;
    localparam logic [3:0] OFF_SUSTAIN = 4'h6;
    localparam logic [3:0] OFF_RELEASE = 4'h7;
    localparam logic [3:0] OFF_LINEAR  = 4'h8;

    localparam int SHAPE_SQUARE = 0;
    localparam int SHAPE_SAW    = 1;
    localparam int SHAPE_TRI    = 2;
    localparam int SHAPE_NOISE  = 4;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    typedef struct packed {
        logic       gate;
        logic [7:0] incr;
        logic [7:0] shape;
        logic [7:0] pw;
        logic [7:0] atk;
        logic [7:0] dcy;
        logic [7:0] sus;
        logic [7:0] rel;
        logic       linear;
    } voice_regs_t;

    // Exponential mode scales the linear step by the current level and never
    // lets a non-zero rate stall; rate 0 always yields a zero step.
    function automatic logic [ENV_W-1:0] env_step(input logic [7:0] rate,
                                                  input logic       linear,
                                                  input logic [7:0] level);
        logic [ENV_W-1:0] base;
        logic [31:0]      scaled;
        logic [ENV_W-1:0] step;
        base   = ENV_W'(rate) << ENV_SHIFT;
        scaled = 32'(base) * 32'(level);
        step   = ENV_W'(scaled >> 8);
        if (rate == 8'h00)
            env_step = '0;
        else if (linear)
            env_step = base;
        else if (step == '0)
            env_step = ENV_W'(1);
        else
            env_step = step;
    endfunction

endpackage

// File: rtl/synth_voice.sv
// One voice: register slice, phase-accumulator oscillator with noise LFSR, ADSR envelope.
// Latency: register writes take effect on the write edge; sample is combinational from phase/env.
// Backpressure: none, free-running every core_clk cycle.
module synth_voice
    import synth_pkg::*;
(
    input  logic                core_clk,
    input  logic                rst,
    input  logic                wr_vld,
    input  logic [3:0]          wr_off,
    input  logic [7:0]          wr_dat,
    input  logic [3:0]          rd_off,
    output logic [7:0]          rd_dat,
    output logic [SAMPLE_W-1:0] sample
);

    voice_regs_t        regs;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_nxt;
    logic [LFSR_W-1:0]  lfsr;
    env_state_t         state;
    env_state_t         state_nxt;
    logic [ENV_W-1:0]   env;
    logic [ENV_W-1:0]   env_nxt;
    logic [ENV_W-1:0]   target;
    logic [ENV_W-1:0]   step;
    logic [ENV_W:0]     sum;
    logic [ENV_W:0]     lim;
    logic [7:0]         rate;
    logic               gate_on;
    logic               gate_off;
    logic [7:0]         sq;
    logic [7:0]         saw;
    logic [7:0]         tri_w;
    logic [7:0]         shape8;
    logic [15:0]        prod;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            regs <= '0;
        end else if (wr_vld) begin
            case (wr_off)
                OFF_GATE:    regs.gate   <= wr_dat[0];
                OFF_INCR:    regs.incr   <= wr_dat;
                OFF_SHAPE:   regs.shape  <= wr_dat;
                OFF_PW:      regs.pw     <= wr_dat;
                OFF_ATTACK:  regs.atk    <= wr_dat;
                OFF_DECAY:   regs.dcy    <= wr_dat;
                OFF_SUSTAIN: regs.sus    <= wr_dat;
                OFF_RELEASE: regs.rel    <= wr_dat;
                OFF_LINEAR:  regs.linear <= wr_dat[0];
                default:     ;
            endcase
        end
    end

    always_comb begin
        rd_dat = 8'h00;
        case (rd_off)
            OFF_GATE:    rd_dat = {7'h00, regs.gate};
            OFF_INCR:    rd_dat = regs.incr;
            OFF_SHAPE:   rd_dat = regs.shape;
            OFF_PW:      rd_dat = regs.pw;
            OFF_ATTACK:  rd_dat = regs.atk;
            OFF_DECAY:   rd_dat = regs.dcy;
            OFF_SUSTAIN: rd_dat = regs.sus;
            OFF_RELEASE: rd_dat = regs.rel;
            OFF_LINEAR:  rd_dat = {7'h00, regs.linear};
            default:     rd_dat = 8'h00;
        endcase
    end

    // Only a change of the gate value starts a new envelope phase.
    assign gate_on  = wr_vld && (wr_off == OFF_GATE) &&  wr_dat[0] && !regs.gate;
    assign gate_off = wr_vld && (wr_off == OFF_GATE) && !wr_dat[0] &&  regs.gate;

    assign phase_nxt = phase + (PHASE_W'(regs.incr) << PHASE_SHIFT);

    always_ff @(posedge core_clk) begin
        if (rst) begin
            phase <= '0;
            lfsr  <= LFSR_W'(1);
        end else begin
            phase <= phase_nxt;
            if (!phase[19] && phase_nxt[19])
                lfsr <= {lfsr[LFSR_W-2:0], lfsr[22] ^ lfsr[17]};
        end
    end

    always_comb begin
        sq     = (phase[23:16] < regs.pw) ? 8'hFF : 8'h00;
        saw    = phase[23:16];
        tri_w  = phase[23] ? ~phase[22:15] : phase[22:15];
        shape8 = 8'hFF;
        if (regs.shape[SHAPE_SQUARE]) shape8 = shape8 & sq;
        if (regs.shape[SHAPE_SAW])    shape8 = shape8 & saw;
        if (regs.shape[SHAPE_TRI])    shape8 = shape8 & tri_w;
        if (regs.shape[SHAPE_NOISE])  shape8 = shape8 & lfsr[7:0];
        if (!(regs.shape[SHAPE_SQUARE] || regs.shape[SHAPE_SAW] ||
              regs.shape[SHAPE_TRI]    || regs.shape[SHAPE_NOISE]))
            shape8 = 8'h00;
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            state <= ENV_IDLE;
            env   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        target    = {regs.sus, 16'h0000};
        case (state)
            ENV_ATTACK:  rate = regs.atk;
            ENV_DECAY:   rate = regs.dcy;
            ENV_RELEASE: rate = regs.rel;
            default:     rate = 8'h00;
        endcase
        step = env_step(rate, regs.linear, env[ENV_W-1 -: 8]);
        sum  = {1'b0, env} + {1'b0, step};
        lim  = {1'b0, target} + {1'b0, step};
        case (state)
            ENV_ATTACK: begin
                if (step != '0) begin
                    if (sum >= {1'b0, {ENV_W{1'b1}}}) begin
                        env_nxt   = {ENV_W{1'b1}};
                        state_nxt = ENV_DECAY;
                    end else begin
                        env_nxt = sum[ENV_W-1:0];
                    end
                end
            end
            ENV_DECAY: begin
                if (step != '0) begin
                    if ({1'b0, env} <= lim) begin
                        env_nxt   = target;
                        state_nxt = ENV_SUSTAIN;
                    end else begin
                        env_nxt = env - step;
                    end
                end
            end
            ENV_SUSTAIN: env_nxt = target;
            ENV_RELEASE: begin
                if (step != '0) begin
                    if (env <= step) begin
                        env_nxt   = '0;
                        state_nxt = ENV_IDLE;
                    end else begin
                        env_nxt = env - step;
                    end
                end
            end
            default: ;
        endcase
        // A gate edge restarts from the present level, taking no step that cycle.
        if (gate_on) begin
            state_nxt = ENV_ATTACK;
            env_nxt   = env;
        end else if (gate_off) begin
            state_nxt = ENV_RELEASE;
            env_nxt   = env;
        end
    end

    assign prod   = 16'(shape8) * 16'(env[ENV_W-1 -: 8]);
    assign sample = {prod, 8'h00};

endmodule

// File: rtl/synth_top.sv
// Two-voice synth core: bus strobe sync, register decode/readback, voice mixer.
// Latency: writes land 2 Clock edges after the BusClock rise; Waveform is 1 cycle after shape/env.
// Backpressure: none; host must hold address/data for at least 2 Clock cycles.
module synth_top
    import synth_pkg::*;
(
    input  logic                Clock,
    input  logic                Reset,
    input  logic [15:0]         BusAddress,
    inout  wire  [7:0]          BusData,
    input  logic                BusReadWrite,
    input  logic                BusClock,
    input  logic [1:0]          WaveType,
    output logic [SAMPLE_W-1:0] Waveform
);

    localparam int MIX_W = SAMPLE_W + $clog2(VOICES);

    logic                b1;
    logic                b2;
    logic                wr_fire;
    logic                hit;
    logic [3:0]          page;
    logic [7:0]          rd_dat;
    logic [7:0]          voice_rd  [VOICES];
    logic [SAMPLE_W-1:0] voice_out [VOICES];
    logic [MIX_W-1:0]    mix_sum;
    logic [SAMPLE_W-1:0] mix;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            b1 <= 1'b0;
            b2 <= 1'b0;
        end else begin
            b1 <= BusClock;
            b2 <= b1;
        end
    end

    // Address and data are taken raw in the fire cycle; the host holds them long enough.
    assign wr_fire = b1 && !b2 && BusReadWrite;
    assign page    = BusAddress[7:4];
    assign hit     = (BusAddress[15:8] == 8'h00) && (page != 4'h0) && (page <= 4'(VOICES));

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        synth_voice u_voice (
            .core_clk (Clock),
            .rst      (Reset),
            .wr_vld   (wr_fire && hit && (page == 4'(v + 1))),
            .wr_off   (BusAddress[3:0]),
            .wr_dat   (BusData),
            .rd_off   (BusAddress[3:0]),
            .rd_dat   (voice_rd[v]),
            .sample   (voice_out[v])
        );
    end

    always_comb begin
        rd_dat = 8'h00;
        for (int v = 0; v < VOICES; v++)
            if (hit && (page == 4'(v + 1)))
                rd_dat = voice_rd[v];
    end

    assign BusData = BusReadWrite ? 8'hzz : rd_dat;

    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < VOICES; v++)
            mix_sum = mix_sum + MIX_W'(voice_out[v]);
        mix = SAMPLE_W'(mix_sum >> $clog2(VOICES));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Waveform <= '0;
        end else begin
            case (WaveType)
                2'b00:   Waveform <= mix;
                2'b01:   Waveform <= voice_out[0];
                2'b10:   Waveform <= voice_out[1];
                default: Waveform <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_synth_top.sv
// Randomized bench for synth_top against a cycle-level arithmetic model of the voices.
module tb_synth_top;

    localparam int ST_IDLE    = 0;
    localparam int ST_ATTACK  = 1;
    localparam int ST_DECAY   = 2;
    localparam int ST_SUSTAIN = 3;
    localparam int ST_RELEASE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rw;
    logic        bclk;
    logic [1:0]  wt;
    logic [23:0] wave;
    logic        tb_drv;
    logic [7:0]  tb_wdat;
    wire  [7:0]  bus_data;

    assign bus_data = tb_drv ? tb_wdat : 8'hzz;

    synth_top dut (
        .Clock        (clk),
        .Reset        (rst),
        .BusAddress   (addr),
        .BusData      (bus_data),
        .BusReadWrite (rw),
        .BusClock     (bclk),
        .WaveType     (wt),
        .Waveform     (wave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: register images indexed by offset, phase, LFSR, envelope.
    int unsigned rm  [2][9];
    int unsigned ph  [2];
    int unsigned lf  [2];
    int unsigned en  [2];
    int          stg [2];
    logic [23:0] m_wave;
    bit          wr_pend;
    logic [15:0] wr_a;
    logic [7:0]  wr_d;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned step_size(input int unsigned rate, input int unsigned lin,
                                              input int unsigned lvl);
        int unsigned base;
        int unsigned s;
        if (rate == 0) return 0;
        base = rate * 16384;
        if (lin != 0) return base;
        s = (base * lvl) / 256;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int unsigned voice_sample(input int v);
        int unsigned sh;
        int unsigned hi;
        int unsigned acc;
        bit          any;
        sh  = rm[v][2];
        hi  = ph[v] / 65536;
        acc = 255;
        any = 0;
        if (sh & 1)  begin any = 1; acc = acc & ((hi < rm[v][3]) ? 255 : 0); end
        if (sh & 2)  begin any = 1; acc = acc & hi; end
        if (sh & 4)  begin
            any = 1;
            acc = acc & ((ph[v] >= 24'h800000) ? (255 - ((ph[v] / 32768) % 256))
                                                : ((ph[v] / 32768) % 256));
        end
        if (sh & 16) begin any = 1; acc = acc & (lf[v] % 256); end
        if (!any) acc = 0;
        return acc * (en[v] / 65536) * 256;
    endfunction

    task automatic env_advance(input int v);
        int unsigned rate;
        int unsigned s;
        int unsigned tgt;
        case (stg[v])
            ST_ATTACK:  rate = rm[v][4];
            ST_DECAY:   rate = rm[v][5];
            ST_RELEASE: rate = rm[v][7];
            default:    rate = 0;
        endcase
        s   = step_size(rate, rm[v][8], en[v] / 65536);
        tgt = rm[v][6] * 65536;
        case (stg[v])
            ST_ATTACK: if (s != 0) begin
                if (en[v] + s >= 32'hFFFFFF) begin en[v] = 32'hFFFFFF; stg[v] = ST_DECAY; end
                else en[v] = en[v] + s;
            end
            ST_DECAY: if (s != 0) begin
                if (int'(en[v]) - int'(s) <= int'(tgt)) begin en[v] = tgt; stg[v] = ST_SUSTAIN; end
                else en[v] = en[v] - s;
            end
            ST_SUSTAIN: en[v] = tgt;
            ST_RELEASE: if (s != 0) begin
                if (int'(en[v]) - int'(s) <= 0) begin en[v] = 0; stg[v] = ST_IDLE; end
                else en[v] = en[v] - s;
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        int unsigned smp [2];
        int unsigned old_en [2];
        int unsigned np;
        logic [23:0] nxt;
        int          v;
        int unsigned off;
        int unsigned val;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = 0; lf[i] = 1; en[i] = 0; stg[i] = ST_IDLE;
                for (int o = 0; o < 9; o++) rm[i][o] = 0;
            end
            m_wave  = 0;
            wr_pend = 0;
            return;
        end
        for (int i = 0; i < 2; i++) smp[i] = voice_sample(i);
        case (wt)
            2'b00:   nxt = 24'((smp[0] + smp[1]) / 2);
            2'b01:   nxt = 24'(smp[0]);
            2'b10:   nxt = 24'(smp[1]);
            default: nxt = 24'h0;
        endcase
        for (int i = 0; i < 2; i++) begin
            old_en[i] = en[i];
            np = (ph[i] + rm[i][1] * 65536) % 32'h1000000;
            if (((ph[i] >> 19) & 1) == 0 && ((np >> 19) & 1) == 1)
                lf[i] = ((lf[i] << 1) | (((lf[i] >> 22) ^ (lf[i] >> 17)) & 1)) & 32'h7FFFFF;
            ph[i] = np;
            env_advance(i);
        end
        if (wr_pend) begin
            wr_pend = 0;
            if (wr_a[15:8] == 0 && wr_a[7:4] >= 1 && wr_a[7:4] <= 2 && wr_a[3:0] <= 8) begin
                v   = int'(wr_a[7:4]) - 1;
                off = wr_a[3:0];
                val = (off == 0 || off == 8) ? (wr_d & 1) : wr_d;
                if (off == 0 && val == 1 && rm[v][0] == 0) begin stg[v] = ST_ATTACK;  en[v] = old_en[v]; end
                if (off == 0 && val == 0 && rm[v][0] == 1) begin stg[v] = ST_RELEASE; en[v] = old_en[v]; end
                rm[v][off] = val;
            end
        end
        m_wave = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk_eq("wave", 32'(wave), 32'(m_wave));
    endtask

    function automatic logic [7:0] exp_read(input logic [15:0] a);
        if (a[15:8] == 0 && a[7:4] >= 1 && a[7:4] <= 2 && a[3:0] <= 8)
            return 8'(rm[int'(a[7:4]) - 1][a[3:0]]);
        return 8'h00;
    endfunction

    task automatic bus_read(input logic [15:0] a);
        addr   = a;
        tb_drv = 0;
        rw     = 0;
        #1;
        chk_eq("read", 32'(bus_data), 32'(exp_read(a)));
        rw = 1;
        tick();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr    = a;
        tb_wdat = d;
        tb_drv  = 1;
        rw      = 1;
        bclk    = 1;
        tick();
        wr_pend = 1; wr_a = a; wr_d = d;
        tick();
        bclk = 0;
        tick();
        tb_drv = 0;
        tick();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        logic [15:0] ra;
        rst = 1; addr = 0; rw = 1; bclk = 0; wt = 2'b00; tb_drv = 0; tb_wdat = 0;
        wr_pend = 0;
        run(3);
        rst = 0;
        for (int o = 0; o < 10; o++) bus_read(16'h0010 + 16'(o));
        bus_read(16'h0026);

        bus_write(16'h0011, 8'h0F);
        bus_read(16'h0011);
        bus_write(16'h0031, 8'h55);
        bus_write(16'h0119, 8'hAA);
        bus_write(16'h0019, 8'hAA);
        bus_read(16'h0031);
        bus_read(16'h0019);
        bus_read(16'h0011);
        bus_read(16'h0021);

        // Voice 1 linear ADSR square note
        wt = 2'b01;
        bus_write(16'h0012, 8'h01);
        bus_write(16'h0013, 8'h3F);
        bus_write(16'h0014, 8'h02);
        bus_write(16'h0015, 8'h05);
        bus_write(16'h0016, 8'h7F);
        bus_write(16'h0017, 8'h05);
        bus_write(16'h0018, 8'h01);
        bus_write(16'h0010, 8'h01);
        bus_write(16'h0010, 8'h01);
        run(700);
        bus_read(16'h0016);
        bus_write(16'h0010, 8'h00);
        run(300);
        chk_eq("idle_wave", 32'(wave), 32'h0);

        // Voice 2 noise, then exponential decay, mixed with a retriggered voice 1
        bus_write(16'h0022, 8'h10);
        bus_write(16'h0021, 8'h03);
        bus_write(16'h0024, 8'h10);
        bus_write(16'h0025, 8'h08);
        bus_write(16'h0026, 8'h40);
        bus_write(16'h0028, 8'h01);
        bus_write(16'h0020, 8'h01);
        bus_write(16'h0010, 8'h01);
        wt = 2'b00;
        run(150);
        bus_write(16'h0028, 8'h00);
        run(300);
        wt = 2'b11;
        tick();
        chk_eq("mute", 32'(wave), 32'h0);
        wt = 2'b10;
        run(20);

        // Mid-note pitch and pulse width change
        wt = 2'b01;
        bus_write(16'h0013, 8'h7F);
        bus_write(16'h0011, 8'h05);
        run(200);

        // Randomized register traffic, output selection and reads
        for (int n = 0; n < 60; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) ra = 16'($urandom_range(0, 16'h0140));
            else ra = {8'h00, 4'($urandom_range(1, 2)), 4'($urandom_range(0, 9))};
            if (r < 5)      bus_write(ra, 8'($urandom));
            else if (r < 7) bus_read(ra);
            else begin
                wt = 2'($urandom_range(0, 3));
                run($urandom_range(5, 80));
            end
        end

        // Reset in the middle of an attack clears everything on the next edge
        wt = 2'b01;
        bus_write(16'h0014, 8'h01);
        bus_write(16'h0018, 8'h01);
        bus_write(16'h0012, 8'h02);
        bus_write(16'h0010, 8'h00);
        bus_write(16'h0010, 8'h01);
        run(40);
        rst = 1;
        tick();
        rst = 0;
        chk_eq("rst_wave", 32'(wave), 32'h0);
        bus_read(16'h0014);
        bus_read(16'h0010);
        bus_read(16'h0022);
        run(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
